// File: rtl/pid_update_scheduler.sv
// pid_update_scheduler: sweeps NUM_MOTORS channels through one shared PID per period.
// Optional build macro PID_SCHED_SKIP_DISABLED_EN: disabled channels are skipped.
module pid_update_scheduler #(
  parameter int NUM_MOTORS     = 6,
  parameter int PERIOD_CYCLES  = 50000,
  parameter int SETTLE_CYCLES  = 2,
  parameter int CAPTURE_CYCLES = 2,
  localparam int IDX_W = (NUM_MOTORS > 1) ? $clog2(NUM_MOTORS) : 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [NUM_MOTORS-1:0]   motor_enable,
  input  logic signed [15:0]      pwm_in,
  output logic [IDX_W-1:0]        motor_sel,
  output logic                    update_controller,
  output logic [16*NUM_MOTORS-1:0] pwm_out,
  output logic [NUM_MOTORS-1:0]   pwm_valid,
  output logic                    busy,
  output logic                    cycle_done,
  output logic                    overrun
);

  localparam int TMAX = (SETTLE_CYCLES > CAPTURE_CYCLES) ?
                        SETTLE_CYCLES : CAPTURE_CYCLES;
  localparam int TW = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int PW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;

  localparam logic [TW-1:0]    SET_LAST = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0]    CAP_LAST = TW'(CAPTURE_CYCLES - 1);
  localparam logic [PW-1:0]    PER_LAST = PW'(PERIOD_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_MOTORS - 1);

  typedef enum logic [2:0] {
    IDLE, SELECT, STROBE, WAIT, CAPTURE, DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [TW-1:0]           tmr_q, tmr_d;
  logic [PW-1:0]           per_q, per_d;
  logic [16*NUM_MOTORS-1:0] pwm_q, pwm_d;
  logic                    ovr_q, ovr_d;

  logic                    tick;
  logic                    skip;
  logic                    ch_en;
  logic                    slot_wr;
  logic [15:0]             slot_val;
  logic [NUM_MOTORS-1:0]   sel_oh;

  assign tick      = enable && (per_q == PER_LAST);
  assign motor_sel = idx_q;
  assign pwm_out   = pwm_q;
  assign overrun   = ovr_q;

  // period counter: free-runs while enabled, cleared when disabled
  always_comb begin
    per_d = per_q + 1'b1;
    if (!enable || tick) per_d = '0;
  end

  // one-hot decode of the current channel and its enable bit
  always_comb begin
    sel_oh = '0;
    for (int i = 0; i < NUM_MOTORS; i++) begin
      sel_oh[i] = (idx_q == IDX_W'(i));
    end
    ch_en = |(motor_enable & sel_oh);
  end

`ifdef PID_SCHED_SKIP_DISABLED_EN
  assign skip = !ch_en;
`else
  assign skip = 1'b0;
`endif

  // sweep FSM: next state, strobe and capture control
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    tmr_d    = tmr_q;
    ovr_d    = ovr_q | (tick & (state_q != IDLE));
    slot_wr  = 1'b0;
    slot_val = '0;
    update_controller = 1'b0;
    pwm_valid  = '0;
    cycle_done = 1'b0;
    busy       = (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        if (tick) begin
          idx_d   = '0;
          tmr_d   = '0;
          state_d = SELECT;
        end
      end
      SELECT: begin
        if (skip && tmr_q == '0) begin
          slot_wr = 1'b1;
          tmr_d   = '0;
          if (idx_q == IDX_LAST) state_d = DONE;
          else idx_d = idx_q + 1'b1;
        end else if (tmr_q == SET_LAST) begin
          tmr_d   = '0;
          state_d = STROBE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      STROBE: begin
        update_controller = 1'b1;
        tmr_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (tmr_q == CAP_LAST) begin
          tmr_d   = '0;
          state_d = CAPTURE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      CAPTURE: begin
        pwm_valid = sel_oh;
        slot_wr   = 1'b1;
        slot_val  = ch_en ? pwm_in : 16'd0;
        tmr_d     = '0;
        if (idx_q == IDX_LAST) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = SELECT;
        end
      end
      DONE: begin
        cycle_done = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // PWM slot bank write port
  always_comb begin
    pwm_d = pwm_q;
    for (int i = 0; i < NUM_MOTORS; i++) begin
      if (slot_wr && sel_oh[i]) pwm_d[16*i +: 16] = slot_val;
    end
  end

  // state registers, async reset returns everything to zero
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      tmr_q   <= '0;
      per_q   <= '0;
      pwm_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tmr_q   <= tmr_d;
      per_q   <= per_d;
      pwm_q   <= pwm_d;
      ovr_q   <= ovr_d;
    end
  end

endmodule

// File: tb/tb_pid_update_scheduler.sv
// tb_pid_update_scheduler: scoreboard bench for pid_update_scheduler.
// Second instance with a short period exercises overrun.
module tb_pid_update_scheduler;

  localparam int N = 4;

  logic clock = 1'b0;
  logic reset;
  logic enable;
  logic en2;
  logic [N-1:0] motor_enable;
  logic neg_mode;
  logic neg2;

  logic signed [15:0] pwm_in;
  logic [1:0]     motor_sel;
  logic           update_controller;
  logic [16*N-1:0] pwm_out;
  logic [N-1:0]   pwm_valid;
  logic           busy;
  logic           cycle_done;
  logic           overrun;

  logic signed [15:0] pwm_in2;
  logic [1:0]     sel2;
  logic           uc2;
  logic [16*N-1:0] pwm2;
  logic [N-1:0]   pv2;
  logic           busy2;
  logic           done2;
  logic           ovr2;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          idx;
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];

  logic [1:0]   h_sel[$];
  logic         h_uc[$];
  logic         h_busy[$];
  logic [N-1:0] h_val[$];
  int           done_at;

  always #5 clock = ~clock;

  assign pwm_in  = neg_mode ? -16'sd500 : 16'(100 * (int'(motor_sel) + 1));
  assign pwm_in2 = neg2 ? -16'sd500 : 16'(100 * (int'(sel2) + 1));

  pid_update_scheduler #(
    .NUM_MOTORS(N), .PERIOD_CYCLES(100),
    .SETTLE_CYCLES(2), .CAPTURE_CYCLES(2)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .motor_enable(motor_enable), .pwm_in(pwm_in),
    .motor_sel(motor_sel), .update_controller(update_controller),
    .pwm_out(pwm_out), .pwm_valid(pwm_valid), .busy(busy),
    .cycle_done(cycle_done), .overrun(overrun)
  );

  pid_update_scheduler #(
    .NUM_MOTORS(N), .PERIOD_CYCLES(20),
    .SETTLE_CYCLES(2), .CAPTURE_CYCLES(2)
  ) u_ovr (
    .clock(clock), .reset(reset), .enable(en2),
    .motor_enable(motor_enable), .pwm_in(pwm_in2),
    .motor_sel(sel2), .update_controller(uc2),
    .pwm_out(pwm2), .pwm_valid(pv2), .busy(busy2),
    .cycle_done(done2), .overrun(ovr2)
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input int idx, input logic [15:0] val);
    exp_t e;
    e.idx = idx;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic adv(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // sample one sweep; caller is positioned in cycle 0
  task automatic record(input int limit);
    h_sel.delete();
    h_uc.delete();
    h_busy.delete();
    h_val.delete();
    done_at = -1;
    for (int c = 0; c < limit; c++) begin
      h_sel.push_back(motor_sel);
      h_uc.push_back(update_controller);
      h_busy.push_back(busy);
      h_val.push_back(pwm_valid);
      if (cycle_done && done_at < 0) done_at = c;
      if (done_at >= 0 && c == done_at + 1) break;
      adv(1);
    end
  endtask

  task automatic analyze(input string tag, input int first_s,
                         input int n_s, input int done_exp);
    int rises;
    int first;
    int bad;
    logic [N-1:0] one;
    rises = 0;
    first = -1;
    bad = 0;
    one = 1;
    for (int c = 1; c < h_uc.size(); c++) begin
      if (h_uc[c] && !h_uc[c-1]) begin
        rises++;
        if (first < 0) first = c;
        if (c < 2 || c + 3 >= h_uc.size()) begin
          bad++;
        end else begin
          if (h_uc[c+1]) bad++;
          for (int k = -2; k <= 3; k++)
            if (h_sel[c+k] !== h_sel[c]) bad++;
          if (h_val[c+3] !== (one << h_sel[c])) bad++;
        end
      end
    end
    chk({tag, " first strobe"}, first, first_s);
    chk({tag, " strobes"}, rises, n_s);
    chk({tag, " shape"}, bad, 0);
    chk({tag, " done at"}, done_at, done_exp);
    chk({tag, " busy after"}, h_busy[h_busy.size()-1], 0);
  endtask

  // monitor: pop expected entry on every pwm_valid pulse
  exp_t         me;
  logic [N-1:0] mv;
  logic [N-1:0] mone;
  initial begin
    mone = 1;
    forever begin
      @(negedge clock);
      if (!reset && pwm_valid != '0) begin
        mv = pwm_valid;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: pwm_valid=%b, expected none", mv);
        end else begin
          me = sb.pop_front();
          chk("sb_valid", mv, mone << me.idx);
          @(negedge clock);
          chk("sb_slot", pwm_out[16*me.idx +: 16], me.val);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  int   rises;
  int   dones;
  int   dpos;
  logic prev;

  initial begin
    reset = 1'b1;
    enable = 1'b0;
    en2 = 1'b0;
    motor_enable = '1;
    neg_mode = 1'b0;
    neg2 = 1'b0;
    #12;
    chk("rst pwm_out", pwm_out, 0);
    chk("rst busy", busy, 0);
    chk("rst strobe", update_controller, 0);
    chk("rst valid", pwm_valid, 0);
    chk("rst done", cycle_done, 0);
    chk("rst overrun", overrun, 0);
    chk("rst sel", motor_sel, 0);

    // basic sweep
    enable = 1'b1;
    push(0, 16'd100); push(1, 16'd200);
    push(2, 16'd300); push(3, 16'd400);
    @(negedge clock);
    reset = 1'b0;
    record(300);
    analyze("t1", 102, 4, 124);
    chk("t1 slots", pwm_out, {16'd400, 16'd300, 16'd200, 16'd100});

    // overrun with a period shorter than the sweep
    @(negedge clock);
    enable = 1'b0;
    en2 = 1'b1;
    adv(30);
    chk("t3 ovr early", ovr2, 0);
    chk("t3 busy", busy2, 1);
    adv(11);
    chk("t3 ovr set", ovr2, 1);
    adv(4);
    chk("t3 idle", busy2, 0);
    chk("t3 slots1", pwm2, {16'd400, 16'd300, 16'd200, 16'd100});
    neg2 = 1'b1;
    adv(40);
    chk("t3 slots2", pwm2, {4{16'hFE0C}});
    adv(115);
    chk("t3 ovr sticky", ovr2, 1);
    @(negedge clock);
    en2 = 1'b0;

    // partial enable mask, negative PID result
    motor_enable = 4'b1010;
    neg_mode = 1'b1;
`ifdef PID_SCHED_SKIP_DISABLED_EN
    push(1, 16'hFE0C); push(3, 16'hFE0C);
`else
    push(0, 16'h0); push(1, 16'hFE0C);
    push(2, 16'h0); push(3, 16'hFE0C);
`endif
    @(negedge clock);
    enable = 1'b1;
    record(300);
`ifdef PID_SCHED_SKIP_DISABLED_EN
    analyze("t4", 103, 2, 114);
`else
    analyze("t4", 102, 4, 124);
`endif
    chk("t4 slots", pwm_out, {16'hFE0C, 16'h0, 16'hFE0C, 16'h0});
    @(negedge clock);
    enable = 1'b0;

    // enable dropped mid-sweep
    motor_enable = '1;
    neg_mode = 1'b0;
    push(0, 16'd100); push(1, 16'd200);
    push(2, 16'd300); push(3, 16'd400);
    @(negedge clock);
    enable = 1'b1;
    adv(110);
    enable = 1'b0;
    rises = 0;
    dones = 0;
    dpos = -1;
    prev = update_controller;
    for (int c = 1; c <= 500; c++) begin
      adv(1);
      if (update_controller && !prev) rises++;
      prev = update_controller;
      if (cycle_done) begin
        dones++;
        if (dpos < 0) dpos = c;
      end
    end
    chk("t6 strobes after", rises, 2);
    chk("t6 done pulses", dones, 1);
    chk("t6 done pos", dpos, 14);
    chk("t6 slots", pwm_out, {16'd400, 16'd300, 16'd200, 16'd100});
    push(0, 16'd100); push(1, 16'd200);
    push(2, 16'd300); push(3, 16'd400);
    @(negedge clock);
    enable = 1'b1;
    record(300);
    analyze("t6 re", 102, 4, 124);

    // reset during WAIT of channel 2
    @(negedge clock);
    enable = 1'b0;
    neg_mode = 1'b1;
    push(0, 16'hFE0C); push(1, 16'hFE0C);
    @(negedge clock);
    enable = 1'b1;
    adv(116);
    chk("t5 pre busy", busy, 1);
    chk("t5 pre sel", motor_sel, 2);
    reset = 1'b1;
    #1;
    chk("t5 busy", busy, 0);
    chk("t5 strobe", update_controller, 0);
    chk("t5 pwm_out", pwm_out, 0);
    chk("t5 sel", motor_sel, 0);
    chk("t5 ovr cleared", ovr2, 0);
    chk("t5 sb drained", sb.size(), 0);
    neg_mode = 1'b0;
    push(0, 16'd100); push(1, 16'd200);
    push(2, 16'd300); push(3, 16'd400);
    @(negedge clock);
    reset = 1'b0;
    record(300);
    analyze("t5 post", 102, 4, 124);
    chk("t5 idle at 99", h_busy[99], 0);
    chk("t5 busy at 100", h_busy[100], 1);

    adv(3);
    chk("sb empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
